// File: rtl/axi_sram_slave.sv
// AXI4-style single-outstanding SRAM responder: read bursts on AR/R, write bursts on AW/W/B,
// backed by a byte-lane-split 64-bit array with a programmable first-beat read latency.
`timescale 1ns/1ps

module axi_sram_slave #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [1:0]  arburst,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    output logic        arready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    output logic        rlast,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    input  logic [1:0]  awburst,
    input  logic [7:0]  awlen,
    output logic        awready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN       = 32'(DEPTH * 8);
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RWAIT,
        S_RDATA,
        S_WDATA,
        S_WRESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  lat_q, lat_d;
    logic        werr_q, werr_d;
    logic        ar_en_q, ar_en_d;
    logic        awready_q, awready_d;
    logic        rvalid_q, rvalid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [31:0]      rd_step_addr;
    logic [31:0]      rd_addr;
    logic [31:0]      rd_off;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_err;
    logic [63:0]      rd_word;
    logic [31:0]      wr_off;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_ok;
    logic             w_hs;
    logic             ar_hs;
    logic             aw_hs;
    logic             werr_nxt;
    logic [7:0]       wr_lane_en;

    // A pending write blocks the read channel so the write always wins the IDLE arbitration.
    assign arready = ar_en_q && !awvalid;
    assign awready = awready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

    // The read port looks at the beat being issued next: beat 0 in RWAIT, beat n+1 in RDATA.
    always_comb begin
        rd_step_addr = (burst_q == BURST_INCR) ? addr_q + (32'd1 << size_q) : addr_q;
        rd_addr      = (state_q == S_RDATA) ? rd_step_addr : addr_q;
        rd_off       = rd_addr - BASE_ADDR;
        rd_idx       = IDX_W'(rd_off >> 3);
        rd_err       = burst_q[1] || (rd_off >= SPAN);
        wr_off       = addr_q - BASE_ADDR;
        wr_idx       = IDX_W'(wr_off >> 3);
        wr_ok        = !burst_q[1] && (wr_off < SPAN);
        ar_hs        = (state_q == S_IDLE) && arvalid && arready;
        aw_hs        = (state_q == S_IDLE) && awvalid && awready_q;
        w_hs         = (state_q == S_WDATA) && wvalid && wready_q;
        wr_lane_en   = (w_hs && wr_ok) ? wstrb : 8'h00;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_lane_en[gi]) begin
                    lane_mem[wr_idx] <= wdata[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[rd_idx];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        burst_d   = burst_q;
        lat_d     = lat_q;
        werr_d    = werr_q;
        ar_en_d   = ar_en_q;
        awready_d = awready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        werr_nxt  = werr_q;

        case (state_q)
            S_IDLE: begin
                ar_en_d   = 1'b1;
                awready_d = 1'b1;
                if (aw_hs) begin
                    addr_d    = awaddr;
                    burst_d   = awburst;
                    len_d     = awlen;
                    beat_d    = 8'd0;
                    werr_d    = 1'b0;
                    ar_en_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    state_d   = S_WDATA;
                end else if (ar_hs) begin
                    addr_d    = araddr;
                    burst_d   = arburst;
                    len_d     = arlen;
                    size_d    = arsize;
                    beat_d    = 8'd0;
                    lat_d     = 4'(RD_LAT - 1);
                    ar_en_d   = 1'b0;
                    awready_d = 1'b0;
                    state_d   = S_RWAIT;
                end
            end

            S_RWAIT: begin
                if (lat_q == 4'd0) begin
                    rvalid_d = 1'b1;
                    rdata_d  = rd_err ? 64'd0 : rd_word;
                    rresp_d  = rd_err ? RESP_SLV : RESP_OKAY;
                    rlast_d  = (len_q == 8'd0);
                    state_d  = S_RDATA;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end

            S_RDATA: begin
                if (rvalid_q && rready) begin
                    if (beat_q == len_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rdata_d   = 64'd0;
                        rresp_d   = RESP_OKAY;
                        ar_en_d   = 1'b1;
                        awready_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        beat_d   = beat_q + 8'd1;
                        addr_d   = rd_step_addr;
                        rvalid_d = 1'b1;
                        rdata_d  = rd_err ? 64'd0 : rd_word;
                        rresp_d  = rd_err ? RESP_SLV : RESP_OKAY;
                        rlast_d  = ((beat_q + 8'd1) == len_q);
                    end
                end
            end

            S_WDATA: begin
                if (w_hs) begin
                    // Sticky: any bad beat (range, burst type or wlast placement) fails the burst.
                    werr_nxt = werr_q || !wr_ok || (wlast != (beat_q == len_q));
                    werr_d   = werr_nxt;
                    if (beat_q == len_q) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = werr_nxt ? RESP_SLV : RESP_OKAY;
                        state_d  = S_WRESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = (burst_q == BURST_INCR) ? addr_q + 32'd8 : addr_q;
                    end
                end
            end

            S_WRESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    ar_en_d   = 1'b1;
                    awready_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            lat_q     <= 4'd0;
            werr_q    <= 1'b0;
            ar_en_q   <= 1'b0;
            awready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 64'd0;
            rresp_q   <= 2'd0;
            rlast_q   <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            lat_q     <= lat_d;
            werr_q    <= werr_d;
            ar_en_q   <= ar_en_d;
            awready_q <= awready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: drivers push expected R beats / B responses from a
// word-level memory model; a negedge monitor drives ready signals and checks every handshake.
`timescale 1ns/1ps

module tb_axi_sram_slave;

    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic [1:0]  arburst = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic [1:0]  awburst = '0;
    logic [7:0]  awlen = '0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axi_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen), .arsize(arsize),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast),
        .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst), .awlen(awlen),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rq [$];
    logic [1:0]  bq [$];
    logic [63:0] mdl [int];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    int checks = 0;
    int failures = 0;
    int rmode = 0;          // 0 random rready, 1 always high, 2 always low
    int rstall_beat = -1;
    int rstall_left = 0;
    int bstall_left = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake t=%0t", name, $time);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint la, lb;
        la = {32'd0, a};
        lb = {32'd0, BASE};
        return (la >= lb) && (la < lb + longint'(DEPTH) * 8);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 3);
    endfunction

    task automatic expect_read(input logic [31:0] addr, input logic [1:0] burst, input int len,
                               input logic [2:0] size);
        rbeat_t e;
        logic [31:0] a;
        logic [31:0] step;
        bit bad;
        step = 32'd1 << size;
        for (int i = 0; i <= len; i++) begin
            a = (burst == 2'b01) ? addr + 32'(i) * step : addr;
            bad = burst[1] || !in_rng(a);
            e.data = bad ? 64'd0 : (mdl.exists(widx(a)) ? mdl[widx(a)] : 64'd0);
            e.resp = bad ? 2'b10 : 2'b00;
            e.last = (i == len);
            rq.push_back(e);
        end
    endtask

    task automatic apply_write(input logic [31:0] addr, input logic [1:0] burst, input int len,
                               input int bad_beat);
        logic [31:0] a;
        logic [63:0] w;
        bit err;
        err = 0;
        for (int i = 0; i <= len; i++) begin
            a = (burst == 2'b01) ? addr + 32'(8 * i) : addr;
            if (i == bad_beat) err = 1;
            if (burst[1] || !in_rng(a)) begin
                err = 1;
            end else begin
                w = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'd0;
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
                mdl[widx(a)] = w;
            end
        end
        bq.push_back(err ? 2'b10 : 2'b00);
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [1:0] burst, input int len,
                         input logic [2:0] size);
        int n;
        int lat;
        bit hs;
        n = 0;
        hs = 0;
        @(posedge clk); #1;
        araddr = addr; arburst = burst; arlen = 8'(len); arsize = size; arvalid = 1'b1;
        while (!hs && n < 2000) begin
            @(negedge clk);
            hs = arready && !rst;
            @(posedge clk);
            n++;
        end
        #1 arvalid = 1'b0;
        if (!hs) begin
            fail_timeout("ar_handshake");
            return;
        end
        $display("RD addr=%h burst=%0d len=%0d size=%0d", addr, burst, len, size);
        expect_read(addr, burst, len, size);
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rvalid) break;
        end
        chk("rd_latency", lat, RD_LAT);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [1:0] burst, input int len,
                            input int bad_beat, input bit gaps);
        int n;
        bit hs;
        n = 0;
        hs = 0;
        @(posedge clk); #1;
        awaddr = addr; awburst = burst; awlen = 8'(len); awvalid = 1'b1;
        while (!hs && n < 2000) begin
            @(negedge clk);
            hs = awready && !rst;
            @(posedge clk);
            n++;
        end
        #1 awvalid = 1'b0;
        if (!hs) begin
            fail_timeout("aw_handshake");
            return;
        end
        $display("WR addr=%h burst=%0d len=%0d bad_wlast_beat=%0d", addr, burst, len, bad_beat);
        apply_write(addr, burst, len, bad_beat);
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            wdata = wd[i]; wstrb = ws[i];
            wlast = (i == len) ^ (i == bad_beat);
            wvalid = 1'b1;
            hs = 0;
            n = 0;
            while (!hs && n < 200) begin
                @(negedge clk);
                hs = wready;
                @(posedge clk);
                n++;
            end
            #1 wvalid = 1'b0;
            if (!hs) begin
                fail_timeout("w_handshake");
                return;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (rq.size() != 0 || bq.size() != 0) fail_timeout("drain");
        repeat (2) @(posedge clk);
    endtask

    // Monitor: decides ready for the coming edge, then scores any handshake that edge will complete.
    initial begin
        rbeat_t      e;
        logic [63:0] p_rdata;
        logic [1:0]  p_rresp;
        logic [1:0]  p_bresp;
        logic        p_rlast;
        bit          p_rstall;
        bit          p_bstall;
        int          beat_idx;
        p_rstall = 0;
        p_bstall = 0;
        beat_idx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_rstall = 0;
                p_bstall = 0;
                beat_idx = 0;
                rready = 1'b0;
                bready = 1'b0;
                continue;
            end
            if (p_rstall) chk("r_hold", {rvalid, rlast, rresp, rdata}, {1'b1, p_rlast, p_rresp, p_rdata});
            if (p_bstall) chk("b_hold", {bvalid, bresp}, {1'b1, p_bresp});

            if (rvalid && beat_idx == rstall_beat && rstall_left > 0) begin
                rready = 1'b0;
                rstall_left--;
            end else begin
                case (rmode)
                    0: rready = ($urandom_range(0, 3) != 0);
                    1: rready = 1'b1;
                    default: rready = 1'b0;
                endcase
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = rq.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", rresp, e.resp);
                    chk("rlast", rlast, e.last);
                end
                beat_idx = rlast ? 0 : beat_idx + 1;
            end
            p_rstall = rvalid && !rready;
            p_rdata = rdata; p_rresp = rresp; p_rlast = rlast;

            if (bvalid && bstall_left > 0) begin
                bready = 1'b0;
                bstall_left--;
            end else begin
                bready = ($urandom_range(0, 3) != 0);
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) chk("b_unexpected", 1'b1, 1'b0);
                else chk("bresp", bresp, bq.pop_front());
            end
            p_bstall = bvalid && !bready;
            p_bresp = bresp;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] a;
        int len;
        int bad;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rresp", rresp, 2'd0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_bresp", bresp, 2'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Preload words 0..63 with known content.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) begin
                wd[i] = {$urandom, $urandom};
                ws[i] = 8'hFF;
            end
            if (k == 0) wd[0] = 64'h1122_3344_5566_7788;
            do_write(BASE + 32'(64 * k), 2'b01, 7, -1, 1'b1);
            drain();
        end

        rmode = 1;
        do_ar(BASE, 2'b01, 0, 3'd3);
        drain();

        rstall_beat = 1; rstall_left = 3;
        do_ar(BASE + 32'h10, 2'b01, 3, 3'd3);
        drain();
        rstall_beat = -1; rmode = 0;

        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'h0F;
        wd[1] = {$urandom, $urandom};    ws[1] = 8'hFF;
        bstall_left = 4;
        do_write(BASE + 32'h20, 2'b01, 1, -1, 1'b0);
        drain();
        do_ar(BASE + 32'h20, 2'b01, 1, 3'd3);
        drain();

        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        fork
            do_write(BASE + 32'h40, 2'b01, 0, -1, 1'b0);
            do_ar(BASE + 32'h40, 2'b01, 0, 3'd3);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("ar_blocked_by_aw", arready, 1'b0);
                chk("aw_ready_idle", awready, 1'b1);
            end
        join
        drain();

        do_ar(32'h7FFF_FFF8, 2'b01, 0, 3'd3);
        drain();
        wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom}; ws[0] = 8'hFF; ws[1] = 8'h3C;
        do_write(BASE + 32'h60, 2'b01, 1, 0, 1'b0);
        drain();
        do_ar(BASE, 2'b10, 2, 3'd3);
        drain();
        do_write(BASE, 2'b11, 1, -1, 1'b0);
        drain();
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(BASE + 32'(DEPTH * 8 - 8), 2'b01, 1, -1, 1'b0);
        drain();
        do_ar(BASE + 32'(DEPTH * 8 - 8), 2'b01, 1, 3'd3);
        drain();
        do_ar(32'hFFFF_FFF8, 2'b01, 1, 3'd3);
        drain();
        for (int i = 0; i < 3; i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = 8'(1 << i) | 8'h80;
        end
        do_write(BASE + 32'h80, 2'b00, 2, -1, 1'b0);
        drain();
        do_ar(BASE + 32'h80, 2'b00, 2, 3'd3);
        drain();
        do_ar(BASE, 2'b01, 0, 3'd3);
        drain();

        for (int t = 0; t < 60; t++) begin
            a = BASE + 32'(8 * $urandom_range(0, 48)) + 32'($urandom_range(0, 7));
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                do_ar(a, ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1)),
                      len, 3'($urandom_range(0, 3)));
            end else begin
                for (int i = 0; i <= len; i++) begin
                    wd[i] = {$urandom, $urandom};
                    ws[i] = 8'($urandom);
                end
                bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
                do_write(a, ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 1)),
                         len, bad, 1'b1);
            end
            drain();
        end

        // Asynchronous reset while a read burst is stalled mid-flight.
        rmode = 2;
        do_ar(BASE, 2'b01, 3, 3'd3);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_rvalid", rvalid, 1'b0);
        chk("arst_rlast", rlast, 1'b0);
        chk("arst_arready", arready, 1'b0);
        chk("arst_awready", awready, 1'b0);
        rq.delete();
        @(posedge clk); #1 rst = 1'b0;
        rmode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("post_rst_idle_awready", awready, 1'b1);
        do_ar(BASE + 32'h8, 2'b01, 1, 3'd3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
